// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared game-state and player-state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_FIGHT     = 3'd2,
    S_P1_WIN    = 3'd3,
    S_P2_WIN    = 3'd4,
    S_EQ        = 3'd5
  } game_state_e;

  typedef enum logic [2:0] {
    PS_IDLE   = 3'd0,
    PS_WALK   = 3'd1,
    PS_ATTACK = 3'd2,
    PS_BLOCK  = 3'd3,
    PS_STUN   = 3'd4
  } player_state_e;

  // Widened to 11 bits so the difference of two 10-bit positions never wraps.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] wa;
    logic [10:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

`default_nettype wire

// File: rtl/attack_tracker.sv
// ============================================================================
// attack_tracker : per-player windup counter and invulnerability timer
// Rev 1.0
// ============================================================================
`default_nettype none

module attack_tracker #(
  parameter int WINDUP = 6,
  parameter int INVULN = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic i_fight,
  input  logic i_attacking,
  input  logic i_alive,
  input  logic i_load_inv,
  output logic o_check_fire,
  output logic o_invulnerable
);

  localparam int ATK_W = $clog2(WINDUP + 1);
  localparam int INV_W = $clog2(INVULN + 1);
  localparam logic [ATK_W-1:0] c_windup    = ATK_W'(WINDUP);
  localparam logic [ATK_W-1:0] c_windup_m1 = ATK_W'(WINDUP - 1);
  localparam logic [INV_W-1:0] c_invuln    = INV_W'(INVULN);

  logic [ATK_W-1:0] r_atk_cnt;
  logic [INV_W-1:0] r_inv_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_atk_cnt <= '0;
      r_inv_cnt <= '0;
    end else if (!i_fight) begin
      r_atk_cnt <= '0;
      r_inv_cnt <= '0;
    end else begin
      // Saturation at WINDUP means one check per attack; leaving ATTACK re-arms.
      if (!i_attacking)
        r_atk_cnt <= '0;
      else if (r_atk_cnt != c_windup)
        r_atk_cnt <= r_atk_cnt + 1'b1;

      if (i_load_inv)
        r_inv_cnt <= c_invuln;
      else if (r_inv_cnt != '0)
        r_inv_cnt <= r_inv_cnt - 1'b1;
    end
  end

  assign o_check_fire   = i_fight && i_attacking && i_alive && (r_atk_cnt == c_windup_m1);
  assign o_invulnerable = (r_inv_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/combat_arbiter.sv
// ============================================================================
// combat_arbiter : resolves hits between two fighters and owns both healths
// Rev 1.0
// ============================================================================
`default_nettype none

module combat_arbiter
  import game_pkg::*;
#(
  parameter int         MAX_HEALTH = 5,
  parameter int         WINDUP     = 6,
  parameter logic [9:0] REACH      = 10'd40,
  parameter int         INVULN     = 30,
  parameter int         DAMAGE     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic [2:0] player1_state,
  input  logic [2:0] player2_state,
  input  logic [9:0] p1_x,
  input  logic [9:0] p2_x,
  output logic [2:0] player1_health,
  output logic [2:0] player2_health,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       p1_blocked,
  output logic       p2_blocked
);

  localparam logic [2:0] c_max_health = 3'(MAX_HEALTH);
  localparam logic [2:0] c_damage     = 3'(DAMAGE);

  logic [2:0]  r_p1_health, r_p2_health;
  logic        r_p1_hit, r_p2_hit, r_p1_blocked, r_p2_blocked;
  logic        w_fight, w_refill;
  logic        w_p1_fire, w_p2_fire, w_p1_inv, w_p2_inv;
  logic [10:0] w_dist;
  logic        w_in_reach;
  logic        w_p1_dmg, w_p2_dmg, w_p1_blk, w_p2_blk;

  function automatic logic [2:0] sat_sub(input logic [2:0] h);
    return (h > c_damage) ? (h - c_damage) : 3'd0;
  endfunction

  assign w_fight  = (game_state == S_FIGHT);
  assign w_refill = (game_state == S_IDLE) || (game_state == S_COUNTDOWN);

  attack_tracker #(.WINDUP(WINDUP), .INVULN(INVULN)) u_trk_p1 (
    .clk            (clk),
    .reset          (reset),
    .i_fight        (w_fight),
    .i_attacking    (player1_state == PS_ATTACK),
    .i_alive        (r_p1_health != 3'd0),
    .i_load_inv     (w_p1_dmg),
    .o_check_fire   (w_p1_fire),
    .o_invulnerable (w_p1_inv)
  );

  attack_tracker #(.WINDUP(WINDUP), .INVULN(INVULN)) u_trk_p2 (
    .clk            (clk),
    .reset          (reset),
    .i_fight        (w_fight),
    .i_attacking    (player2_state == PS_ATTACK),
    .i_alive        (r_p2_health != 3'd0),
    .i_load_inv     (w_p2_dmg),
    .o_check_fire   (w_p2_fire),
    .o_invulnerable (w_p2_inv)
  );

  assign w_dist     = abs_diff(p1_x, p2_x);
  assign w_in_reach = (w_dist <= {1'b0, REACH});

  // Each attacker is resolved against the other's current state, so trades land both ways.
  assign w_p2_blk = w_p1_fire && w_in_reach && (player2_state == PS_BLOCK);
  assign w_p2_dmg = w_p1_fire && w_in_reach && (player2_state != PS_BLOCK) && !w_p2_inv;
  assign w_p1_blk = w_p2_fire && w_in_reach && (player1_state == PS_BLOCK);
  assign w_p1_dmg = w_p2_fire && w_in_reach && (player1_state != PS_BLOCK) && !w_p1_inv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_health <= c_max_health;
      r_p2_health <= c_max_health;
    end else if (w_refill) begin
      r_p1_health <= c_max_health;
      r_p2_health <= c_max_health;
    end else if (w_fight) begin
      if (w_p1_dmg) r_p1_health <= sat_sub(r_p1_health);
      if (w_p2_dmg) r_p2_health <= sat_sub(r_p2_health);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_hit     <= 1'b0;
      r_p2_hit     <= 1'b0;
      r_p1_blocked <= 1'b0;
      r_p2_blocked <= 1'b0;
    end else begin
      r_p1_hit     <= w_p1_dmg;
      r_p2_hit     <= w_p2_dmg;
      r_p1_blocked <= w_p1_blk;
      r_p2_blocked <= w_p2_blk;
    end
  end

  assign player1_health = r_p1_health;
  assign player2_health = r_p2_health;
  assign p1_hit         = r_p1_hit;
  assign p2_hit         = r_p2_hit;
  assign p1_blocked     = r_p1_blocked;
  assign p2_blocked     = r_p2_blocked;

endmodule

`default_nettype wire

// File: tb/tb_combat_arbiter.sv
// ============================================================================
// tb_combat_arbiter : directed self-checking bench for combat_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_combat_arbiter;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] game_state, player1_state, player2_state;
  logic [9:0] p1_x, p2_x;
  logic [2:0] player1_health, player2_health;
  logic       p1_hit, p2_hit, p1_blocked, p2_blocked;

  int n_cmp  = 0;
  int n_fail = 0;

  combat_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .game_state     (game_state),
    .player1_state  (player1_state),
    .player2_state  (player2_state),
    .p1_x           (p1_x),
    .p2_x           (p2_x),
    .player1_health (player1_health),
    .player2_health (player2_health),
    .p1_hit         (p1_hit),
    .p2_hit         (p2_hit),
    .p1_blocked     (p1_blocked),
    .p2_blocked     (p2_blocked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill_then_fight();
    game_state    = S_COUNTDOWN;
    player1_state = PS_IDLE;
    player2_state = PS_IDLE;
    tick();
    game_state = S_FIGHT;
  endtask

  task automatic test_reset();
    reset = 1'b1; game_state = S_IDLE; player1_state = PS_IDLE; player2_state = PS_IDLE;
    p1_x = 10'd100; p2_x = 10'd120;
    #3;
    n_cmp++;
    if ({player1_health, player2_health} !== {3'd5, 3'd5}) begin
      $display("FAIL reset_health: got %0d/%0d need 5/5", player1_health, player2_health); n_fail++;
    end
    n_cmp++;
    if ({p1_hit, p2_hit, p1_blocked, p2_blocked} !== 4'b0000) begin
      $display("FAIL reset_pulses: got %b need 0000", {p1_hit, p2_hit, p1_blocked, p2_blocked}); n_fail++;
    end
    @(negedge clk);
    reset = 1'b0; game_state = S_COUNTDOWN;
    tick();
    n_cmp++;
    if ({player1_health, player2_health, p1_hit, p2_hit, p1_blocked, p2_blocked} !== {3'd5, 3'd5, 4'b0000}) begin
      $display("FAIL countdown_state: got h=%0d/%0d pulses=%b need 5/5 0000",
               player1_health, player2_health, {p1_hit, p2_hit, p1_blocked, p2_blocked}); n_fail++;
    end
  endtask

  task automatic test_hit();
    refill_then_fight();
    p1_x = 10'd100; p2_x = 10'd120;
    player1_state = PS_ATTACK;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (p2_hit !== (k == 6)) begin
        $display("FAIL hit_pulse edge %0d: got %b need %b", k, p2_hit, (k == 6)); n_fail++;
      end
      n_cmp++;
      if (player2_health !== ((k >= 6) ? 3'd4 : 3'd5)) begin
        $display("FAIL hit_health edge %0d: got %0d need %0d", k, player2_health, (k >= 6) ? 4 : 5); n_fail++;
      end
      n_cmp++;
      if ({p1_hit, p1_blocked, p2_blocked} !== 3'b000) begin
        $display("FAIL hit_other_pulses edge %0d: got %b need 000", k, {p1_hit, p1_blocked, p2_blocked}); n_fail++;
      end
    end
    player1_state = PS_IDLE;
  endtask

  task automatic test_block();
    refill_then_fight();
    p1_x = 10'd100; p2_x = 10'd120;
    player1_state = PS_ATTACK; player2_state = PS_BLOCK;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (p2_blocked !== (k == 6)) begin
        $display("FAIL block_pulse edge %0d: got %b need %b", k, p2_blocked, (k == 6)); n_fail++;
      end
      n_cmp++;
      if ({p2_hit, player2_health} !== {1'b0, 3'd5}) begin
        $display("FAIL block_no_damage edge %0d: got hit=%b h=%0d need 0/5", k, p2_hit, player2_health); n_fail++;
      end
    end
    player1_state = PS_IDLE; player2_state = PS_IDLE;
  endtask

  task automatic test_reach();
    refill_then_fight();
    p1_x = 10'd100; p2_x = 10'd141;
    player1_state = PS_ATTACK;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({p1_hit, p2_hit, p1_blocked, p2_blocked, player2_health} !== {4'b0000, 3'd5}) begin
        $display("FAIL reach41_whiff edge %0d: got pulses=%b h=%0d need 0000/5",
                 k, {p1_hit, p2_hit, p1_blocked, p2_blocked}, player2_health); n_fail++;
      end
    end
    player1_state = PS_IDLE;
    tick();
    p1_x = 10'd140; p2_x = 10'd100;
    player1_state = PS_ATTACK;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (p2_hit !== (k == 6)) begin
        $display("FAIL reach40_pulse edge %0d: got %b need %b", k, p2_hit, (k == 6)); n_fail++;
      end
    end
    n_cmp++;
    if (player2_health !== 3'd4) begin
      $display("FAIL reach40_health: got %0d need 4", player2_health); n_fail++;
    end
    player1_state = PS_IDLE;
  endtask

  task automatic test_trade();
    refill_then_fight();
    p1_x = 10'd300; p2_x = 10'd300;
    for (int t = 0; t < 5; t++) begin
      player1_state = PS_ATTACK; player2_state = PS_ATTACK;
      for (int k = 1; k <= 6; k++) begin
        tick();
        n_cmp++;
        if ({p1_hit, p2_hit} !== ((k == 6) ? 2'b11 : 2'b00)) begin
          $display("FAIL trade%0d_pulses edge %0d: got %b need %b", t, k, {p1_hit, p2_hit}, (k == 6) ? 2'b11 : 2'b00); n_fail++;
        end
      end
      n_cmp++;
      if ({player1_health, player2_health} !== {3'(4 - t), 3'(4 - t)}) begin
        $display("FAIL trade%0d_health: got %0d/%0d need %0d/%0d", t, player1_health, player2_health, 4 - t, 4 - t); n_fail++;
      end
      player1_state = PS_IDLE; player2_state = PS_IDLE;
      for (int k = 0; k < 31; k++) tick();
    end
    player2_state = PS_ATTACK;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({p1_hit, player1_health} !== {1'b0, 3'd0}) begin
        $display("FAIL dead_attacker edge %0d: got hit=%b h=%0d need 0/0", k, p1_hit, player1_health); n_fail++;
      end
    end
    player2_state = PS_IDLE;
  endtask

  task automatic test_invuln();
    refill_then_fight();
    p1_x = 10'd200; p2_x = 10'd210;
    player1_state = PS_ATTACK;
    for (int k = 0; k < 6; k++) tick();
    n_cmp++;
    if ({p2_hit, player2_health} !== {1'b1, 3'd4}) begin
      $display("FAIL invuln_first_hit: got hit=%b h=%0d need 1/4", p2_hit, player2_health); n_fail++;
    end
    player1_state = PS_IDLE;
    tick();
    player1_state = PS_ATTACK;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if ({p2_hit, player2_health} !== {1'b0, 3'd4}) begin
        $display("FAIL invuln_second edge %0d: got hit=%b h=%0d need 0/4", k, p2_hit, player2_health); n_fail++;
      end
    end
    player1_state = PS_IDLE;
  endtask

  task automatic test_reset_and_win();
    refill_then_fight();
    p1_x = 10'd200; p2_x = 10'd210;
    player1_state = PS_ATTACK;
    for (int k = 0; k < 6; k++) tick();
    player1_state = PS_IDLE;
    n_cmp++;
    if (player2_health !== 3'd4) begin
      $display("FAIL midfight_pre_reset: got %0d need 4", player2_health); n_fail++;
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({player1_health, player2_health, p2_hit} !== {3'd5, 3'd5, 1'b0}) begin
      $display("FAIL async_reset: got h=%0d/%0d hit=%b need 5/5/0", player1_health, player2_health, p2_hit); n_fail++;
    end
    #1 reset = 1'b0;
    player1_state = PS_ATTACK;
    for (int k = 0; k < 6; k++) tick();
    player1_state = PS_IDLE;
    n_cmp++;
    if ({p2_hit, player2_health} !== {1'b1, 3'd4}) begin
      $display("FAIL post_reset_hit: got hit=%b h=%0d need 1/4", p2_hit, player2_health); n_fail++;
    end
    for (int k = 0; k < 31; k++) tick();
    player1_state = PS_ATTACK;
    for (int k = 0; k < 5; k++) tick();
    game_state = S_P1_WIN;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if ({p2_hit, p2_blocked, player1_health, player2_health} !== {2'b00, 3'd5, 3'd4}) begin
        $display("FAIL win_frozen edge %0d: got pulses=%b h=%0d/%0d need 00 5/4",
                 k, {p2_hit, p2_blocked}, player1_health, player2_health); n_fail++;
      end
    end
    player1_state = PS_IDLE;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_block();
    test_reach();
    test_trade();
    test_invuln();
    test_reset_and_win();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
